// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD write engine.
package lcd_pkg;

    localparam int unsigned TMR_W        = 17;
    localparam int unsigned LCD_ON_BIT   = 31;
    localparam int unsigned LCD_BLON_BIT = 30;
    localparam int unsigned LCD_RS_BIT   = 9;

    localparam logic [11:0] LCD_ADDR      = 12'h8A0;
    localparam logic [11:0] LCD_STAT_ADDR = 12'h8A4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        EXEC
    } state_e;

    // Clear (0x01) and home (0x02/0x03) need the long execute wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data[7:2] == 6'b0) && (data[1:0] != 2'b0);
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter; zero_o is high while the count is zero.
module lcd_timer
    import lcd_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [TMR_W-1:0] value_i,
    output logic             zero_o
);

    logic [TMR_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= value_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - TMR_W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780-class bus timing engine: one accepted store becomes a full
// setup / EN pulse / hold / execute-wait write sequence.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned T_SETUP_CYC = 4,
    parameter int unsigned T_PW_CYC    = 25,
    parameter int unsigned T_HOLD_CYC  = 2,
    parameter int unsigned T_EXEC_CYC  = 2500,
    parameter int unsigned T_LONG_CYC  = 82000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lcd_wr_i,
    input  logic [31:0] lcd_wdata_i,
    input  logic        drop_clr_i,
    output logic        busy_o,
    output logic        drop_o,
    output logic        lcd_on_o,
    output logic        lcd_blon_o,
    output logic        lcd_en_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic [7:0]  lcd_data_o
);

    localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(T_SETUP_CYC - 1);
    localparam logic [TMR_W-1:0] PW_LD    = TMR_W'(T_PW_CYC - 1);
    localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(T_HOLD_CYC - 1);
    localparam logic [TMR_W-1:0] EXEC_LD  = TMR_W'(T_EXEC_CYC - 1);
    localparam logic [TMR_W-1:0] LONG_LD  = TMR_W'(T_LONG_CYC - 1);

    state_e           state_q, state_d;
    logic             on_q, on_d;
    logic             blon_q, blon_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;
    logic             drop_q, drop_d;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_value;
    logic             tmr_zero;

    logic unused_wdata;
    assign unused_wdata = ^{lcd_wdata_i[29:10], lcd_wdata_i[8]};

    lcd_timer u_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (tmr_load),
        .value_i (tmr_value),
        .zero_o  (tmr_zero)
    );

    always_comb begin
        state_d   = state_q;
        on_d      = on_q;
        blon_d    = blon_q;
        rs_d      = rs_q;
        data_d    = data_q;
        en_d      = en_q;
        busy_d    = busy_q;
        tmr_load  = 1'b0;
        tmr_value = '0;

        unique case (state_q)
            IDLE: begin
                if (lcd_wr_i) begin
                    on_d      = lcd_wdata_i[LCD_ON_BIT];
                    blon_d    = lcd_wdata_i[LCD_BLON_BIT];
                    rs_d      = lcd_wdata_i[LCD_RS_BIT];
                    data_d    = lcd_wdata_i[7:0];
                    busy_d    = 1'b1;
                    tmr_load  = 1'b1;
                    tmr_value = SETUP_LD;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                if (tmr_zero) begin
                    tmr_load  = 1'b1;
                    tmr_value = PW_LD;
                    en_d      = 1'b1;
                    state_d   = PULSE;
                end
            end
            PULSE: begin
                if (tmr_zero) begin
                    tmr_load  = 1'b1;
                    tmr_value = HOLD_LD;
                    en_d      = 1'b0;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (tmr_zero) begin
                    tmr_load  = 1'b1;
                    tmr_value = is_long_cmd(rs_q, data_q) ? LONG_LD : EXEC_LD;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                if (tmr_zero) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                en_d    = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // A set from a discarded write beats a simultaneous clear.
    always_comb begin
        drop_d = drop_q;
        if (lcd_wr_i && (state_q != IDLE)) begin
            drop_d = 1'b1;
        end else if (drop_clr_i) begin
            drop_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            on_q    <= 1'b0;
            blon_q  <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            on_q    <= on_d;
            blon_q  <= blon_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
        end
    end

    assign busy_o     = busy_q;
    assign drop_o     = drop_q;
    assign lcd_on_o   = on_q;
    assign lcd_blon_o = blon_q;
    assign lcd_en_o   = en_q;
    assign lcd_rs_o   = rs_q;
    assign lcd_rw_o   = 1'b0;
    assign lcd_data_o = data_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: elapsed-time reference model checked every cycle,
// plus directed scenarios with hand-computed cycle counts.
module tb_lcd_ctrl;

    localparam int T_SETUP = 2;
    localparam int T_PW    = 3;
    localparam int T_HOLD  = 1;
    localparam int T_EXEC  = 5;
    localparam int T_LONG  = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic        clr = 1'b0;
    logic        busy, drop, on, blon, en, rs, rw;
    logic [7:0]  data;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    lcd_ctrl #(
        .T_SETUP_CYC (T_SETUP),
        .T_PW_CYC    (T_PW),
        .T_HOLD_CYC  (T_HOLD),
        .T_EXEC_CYC  (T_EXEC),
        .T_LONG_CYC  (T_LONG)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .lcd_wr_i    (wr),
        .lcd_wdata_i (wdata),
        .drop_clr_i  (clr),
        .busy_o      (busy),
        .drop_o      (drop),
        .lcd_on_o    (on),
        .lcd_blon_o  (blon),
        .lcd_en_o    (en),
        .lcd_rs_o    (rs),
        .lcd_rw_o    (rw),
        .lcd_data_o  (data)
    );

    // Reference model: cycles elapsed since the accepting edge decide busy/EN.
    int         m_el = 0;
    int         m_total = 0;
    bit         m_on, m_blon, m_rs, m_drop;
    logic [7:0] m_data;
    bit         m_busy_now;

    function automatic bit exp_busy(int el, int total);
        return (el >= 1) && (el <= total);
    endfunction

    function automatic bit exp_en(int el);
        return (el >= T_SETUP + 1) && (el <= T_SETUP + T_PW);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_el = 0; m_total = 0;
            m_on = 0; m_blon = 0; m_rs = 0; m_data = 8'h00; m_drop = 0;
        end else begin
            m_busy_now = exp_busy(m_el, m_total);
            if (wr && !m_busy_now) begin
                m_on   = wdata[31];
                m_blon = wdata[30];
                m_rs   = wdata[9];
                m_data = wdata[7:0];
                m_total = T_SETUP + T_PW + T_HOLD +
                    ((!m_rs && m_data >= 8'h01 && m_data <= 8'h03) ? T_LONG : T_EXEC);
                m_el = 1;
            end else if (m_el != 0 && m_el <= m_total) begin
                m_el = m_el + 1;
            end
            if (wr && m_busy_now) m_drop = 1;
            else if (clr) m_drop = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(exp_busy(m_el, m_total)));
            chk("en", 32'(en), 32'(exp_en(m_el)));
            chk("drop", 32'(drop), 32'(m_drop));
            chk("on", 32'(on), 32'(m_on));
            chk("blon", 32'(blon), 32'(m_blon));
            chk("rs", 32'(rs), 32'(m_rs));
            chk("data", 32'(data), 32'(m_data));
            chk("rw", 32'(rw), 32'h0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge of cycle 1 after the store.
    task automatic strobe(input logic [31:0] d);
        wr = 1'b1;
        wdata = d;
        step(1);
        wr = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            n++;
            step(1);
        end
        chk("idle_timeout", 32'(busy), 32'h0);
    endtask

    task automatic measure(output int busy_n, output int en_n, output int first_en);
        busy_n = 0; en_n = 0; first_en = 0;
        while (busy && busy_n < 200) begin
            busy_n++;
            if (en) begin
                if (en_n == 0) first_en = busy_n;
                en_n++;
            end
            step(1);
        end
    endtask

    int b_n, e_n, f_en;

    initial begin
        // 1. reset
        step(2);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_en", 32'(en), 32'h0);
        chk("rst_data", 32'(data), 32'h0);
        chk("rst_outs", {28'h0, on, blon, rs, drop}, 32'h0);
        rst = 1'b0;
        chk_en = 1'b1;
        step(1);

        // 2. data write 'A'
        strobe(32'hC000_0241);
        chk("t2_c1", {20'h0, busy, on, blon, rs, data}, 32'h0000_0F41);
        chk("t2_c1_en", 32'(en), 32'h0);
        step(1);
        chk("t2_c2_en", 32'(en), 32'h0);
        step(1);
        chk("t2_c3_en", 32'(en), 32'h1);
        step(2);
        chk("t2_c5_en", 32'(en), 32'h1);
        step(1);
        chk("t2_c6_en", 32'(en), 32'h0);
        step(5);
        chk("t2_c11_busy", 32'(busy), 32'h1);
        step(1);
        chk("t2_c12_busy", 32'(busy), 32'h0);
        step(2);

        // 3. clear command (long) then function set (normal)
        strobe(32'h8000_0001);
        measure(b_n, e_n, f_en);
        chk("t3_long_busy", 32'(b_n), 32'd26);
        chk("t3_long_en", 32'(e_n), 32'd3);
        chk("t3_long_first_en", 32'(f_en), 32'd3);
        chk("t3_blon", 32'(blon), 32'h0);
        step(1);
        strobe(32'h8000_0038);
        measure(b_n, e_n, f_en);
        chk("t3_norm_busy", 32'(b_n), 32'd11);
        chk("t3_norm_en", 32'(e_n), 32'd3);

        // 4. write while busy
        step(1);
        strobe(32'hC000_0242);
        step(3);
        strobe(32'h0000_0003);
        chk("t4_kept", {22'h0, on, rs, data}, 32'h0000_0342);
        chk("t4_drop", 32'(drop), 32'h1);
        wait_idle();
        chk("t4_drop_sticky", 32'(drop), 32'h1);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("t4_drop_clr", 32'(drop), 32'h0);
        strobe(32'h8000_0038);
        step(2);
        wr = 1'b1; wdata = 32'h8000_0001; clr = 1'b1;
        step(1);
        wr = 1'b0; clr = 1'b0;
        chk("t4_set_wins", 32'(drop), 32'h1);
        chk("t4_data_kept", 32'(data), 32'h38);
        wait_idle();
        clr = 1'b1;
        step(1);
        clr = 1'b0;

        // 5. back-to-back on the cycle busy falls
        strobe(32'h8000_0030);
        wait_idle();
        strobe(32'hC000_0248);
        chk("t5_accept", {22'h0, busy, drop, data}, 32'h0000_0248);
        measure(b_n, e_n, f_en);
        chk("t5_busy", 32'(b_n), 32'd11);
        chk("t5_en", 32'(e_n), 32'd3);

        // 6. reset during the EN pulse
        step(1);
        strobe(32'hC000_0245);
        b_n = 0;
        while (!en && b_n < 20) begin
            b_n++;
            step(1);
        end
        chk("t6_en_seen", 32'(en), 32'h1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("t6_rst", {21'h0, en, busy, on, data}, 32'h0);
        step(1);
        strobe(32'h0000_0250);
        measure(b_n, e_n, f_en);
        chk("t6_busy", 32'(b_n), 32'd11);
        chk("t6_first_en", 32'(f_en), 32'd3);
        chk("t6_data", 32'(data), 32'h50);

        step(2);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
